frame_signature: RTL and testbench
==================================

# frame_signature

Self-test stage that sits directly downstream of the SVGA pixel generator. Every clock it folds the generator's video outputs into a CRC-16, using an 8-bit word {hsync, vsync, rrggbb}. At each `next_frame` it latches the result as the frame signature. A captured reference signature is compared against every later frame, and mismatches are counted. The bench uses it to verify colour, sync timing and sprite rendering end-to-end without a frame grabber.

## Interface
- `CRC_INIT`, 16'hFFFF: CRC seed loaded at reset and at every frame boundary.
- `MISMATCH_W`, 8: width of the saturating mismatch counter.
- `clk`  in  1  pixel clock, same clock as the video generator.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rrggbb`  in  6  pixel colour from the generator (zero during blanking).
- `hsync`  in  1  horizontal sync from the generator.
- `vsync`  in  1  vertical sync from the generator.
- `next_frame`  in  1  one-cycle pulse from the generator marking the last clock of a frame.
- `arm`  in  1  one-cycle request to capture the next complete frame as the reference.
- `clear`  in  1  one-cycle request that clears `mismatch` and `mismatch_count`.
- `signature`  out  16  CRC of the last complete frame.
- `sig_valid`  out  1  `signature` holds a complete-frame CRC.
- `sig_strobe`  out  1  one-cycle pulse: `signature` was just updated.
- `frame_count`  out  16  complete frames seen; wraps at 16'hFFFF -> 0.
- `ref_signature`  out  16  captured reference signature.
- `checking`  out  1  a reference is held and comparison is active.
- `mismatch`  out  1  sticky: at least one frame differed from the reference.
- `mismatch_count`  out  MISMATCH_W  number of mismatching frames; saturates at all-ones.

## Operation
- **CRC algorithm:** CRC-16-CCITT, polynomial 0x1021, non-reflected, MSB first, no output XOR.
- **Per-clock update:** each clock, `crc_next` = the 8-bit update of `crc` with byte D = {hsync, vsync, rrggbb[5:0]}. The whole byte is processed in one cycle.
- **Mid-frame clocks:** when `next_frame`=0, `crc` <= `crc_next`.
- **Frame boundary:** when `next_frame`=1, the byte sampled in that cycle still belongs to the ending frame.
  - `crc` <= CRC_INIT.
  - `synced` <= 1.
  - If `synced` was already 1, the frame was complete: `signature` <= `crc_next`, `sig_valid` <= 1, `sig_strobe` <= 1, `frame_count` += 1.
  - If `synced` was 0, the frame was partial: nothing is latched and `frame_count` is unchanged.
- **State machine:** states IDLE, ARMED, CHECK; the reset state is IDLE.
  - IDLE: `arm` -> ARMED.
  - ARMED, on a complete-frame boundary: `ref_signature` <= `crc_next`, -> CHECK. The reference frame is not itself compared.
  - CHECK, on a complete-frame boundary: if `crc_next` != `ref_signature`, `mismatch` <= 1 and `mismatch_count` += 1 (saturating).
  - CHECK: `arm` -> ARMED. `ref_signature` is kept until the recapture, and no comparison is made while ARMED.
  - `checking` = (state == CHECK).
- **arm coinciding with next_frame:** the state moves to ARMED, so the frame ending in that cycle is neither captured nor compared. Capture happens at the following complete-frame boundary.
- **clear:** `clear` zeroes `mismatch` and `mismatch_count`.
  - `clear` and a mismatching boundary in the same cycle: `clear` wins, and both stay zero.
  - `clear` does not affect state, `ref_signature` or `signature`.
- **Reset (including mid-frame):** all of the following take their reset values.
  - `crc`=CRC_INIT, `synced`=0, state IDLE.
  - `signature`=0, `ref_signature`=0, `sig_valid`=0, `sig_strobe`=0.
  - `frame_count`=0, `mismatch`=0, `mismatch_count`=0.
  - Consequence: the first frame after reset is always treated as partial.

## Timing
- All outputs are registered.
- Latency:
  - `signature`, `sig_strobe`, `frame_count`, `ref_signature`, `checking`, `mismatch` and `mismatch_count` all update at the clock edge that samples `next_frame`=1. They are visible in the following cycle.
  - `sig_strobe` is high for exactly that one cycle.
- `arm` and `clear` are sampled on every edge; their effect is visible the next cycle.
- Back-to-back `next_frame` pulses (1-clock frames) are legal; each pulse is a boundary.

## Test plan
- **Reset defaults:** assert `reset_n`=0 -> all outputs are 0 and `checking`=0. Deassert, then apply one `next_frame` -> `sig_valid` stays 0 and `frame_count`=0.
- **Known CRC vector:** after one sync pulse, drive D = 0x31..0x39 over 9 clocks with `next_frame` on the 9th -> next cycle `signature`=16'h29B1, `sig_strobe`=1 for one cycle, `frame_count`=1, `sig_valid`=1.
- **Arm then match:**
  - Pulse `arm`, then run two identical 9-byte "123456789" frames.
  - After the first: `ref_signature`=16'h29B1, `checking`=1.
  - After the second: `mismatch`=0.
  - Flip `rrggbb` bit 0 in one byte of the third frame -> `mismatch`=1, `mismatch_count`=1.
- **Saturation and clear:** with MISMATCH_W=2, run 5 mismatching frames -> `mismatch_count`=3. Pulse `clear` on the boundary cycle of a mismatching frame -> `mismatch`=0, `mismatch_count`=0.
- **arm on a boundary:** assert `arm` in the same cycle as `next_frame` -> no capture at that boundary, `checking`=0. Capture happens at the following boundary.
- **Reset mid-frame:** after 5 frames with `frame_count`=5, reset mid-frame -> all outputs 0. The next boundary is partial; the one after gives `frame_count`=1.

Source files
------------

// File: rtl/frame_signature.sv
// Folds every video clock's {hsync, vsync, rrggbb} byte into a CRC-16-CCITT, latches it per frame,
// and compares frames against a captured reference signature.
module frame_signature #(
    parameter logic [15:0] CRC_INIT   = 16'hFFFF,
    parameter int          MISMATCH_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [5:0]            rrggbb,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  next_frame,
    input  logic                  arm,
    input  logic                  clear,
    output logic [15:0]           signature,
    output logic                  sig_valid,
    output logic                  sig_strobe,
    output logic [15:0]           frame_count,
    output logic [15:0]           ref_signature,
    output logic                  checking,
    output logic                  mismatch,
    output logic [MISMATCH_W-1:0] mismatch_count
);

    typedef enum logic [1:0] {IDLE, ARMED, CHECK} state_t;

    state_t      state;
    logic [15:0] crc;
    logic [15:0] crc_next;
    logic        synced;
    logic        complete;
    logic        mis_hit;

    // Poly 0x1021, MSB first; eight bit-steps unrolled into one cycle.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        crc_next = crc_byte(crc, {hsync, vsync, rrggbb});
        complete = next_frame & synced;
        // arm takes priority: a frame ending with arm high is neither captured nor compared
        mis_hit  = (state == CHECK) && !arm && complete && (crc_next != ref_signature);
    end

    assign checking = (state == CHECK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc            <= CRC_INIT;
            synced         <= 1'b0;
            state          <= IDLE;
            signature      <= '0;
            ref_signature  <= '0;
            sig_valid      <= 1'b0;
            sig_strobe     <= 1'b0;
            frame_count    <= '0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
        end else begin
            sig_strobe <= 1'b0;
            if (next_frame) begin
                crc    <= CRC_INIT;
                synced <= 1'b1;
            end else begin
                crc <= crc_next;
            end

            if (complete) begin
                signature   <= crc_next;
                sig_valid   <= 1'b1;
                sig_strobe  <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end

            if (arm) begin
                state <= ARMED;
            end else if (complete && state == ARMED) begin
                ref_signature <= crc_next;
                state         <= CHECK;
            end

            if (clear) begin
                mismatch       <= 1'b0;
                mismatch_count <= '0;
            end else if (mis_hit) begin
                mismatch <= 1'b1;
                if (mismatch_count != {MISMATCH_W{1'b1}})
                    mismatch_count <= mismatch_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_signature.sv
// Bench for frame_signature: directed scenarios with literal expectations plus a randomized run,
// all cycles checked against a frame-level behavioural model.
module tb_frame_signature;

    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [5:0]    rrggbb = '0;
    logic          hsync = 1'b0, vsync = 1'b0, next_frame = 1'b0, arm = 1'b0, clear = 1'b0;
    logic [15:0]   signature, frame_count, ref_signature;
    logic          sig_valid, sig_strobe, checking, mismatch;
    logic [MW-1:0] mismatch_count;

    frame_signature #(.CRC_INIT(16'hFFFF), .MISMATCH_W(MW)) dut (
        .clk(clk), .reset_n(reset_n), .rrggbb(rrggbb), .hsync(hsync), .vsync(vsync),
        .next_frame(next_frame), .arm(arm), .clear(clear), .signature(signature),
        .sig_valid(sig_valid), .sig_strobe(sig_strobe), .frame_count(frame_count),
        .ref_signature(ref_signature), .checking(checking), .mismatch(mismatch),
        .mismatch_count(mismatch_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;

    // Model state: bytes of the frame in progress, plus frame-level outcome variables.
    logic [7:0]  frame_q[$];
    bit          m_synced, m_armed, m_checking, m_valid, m_strobe, m_mis;
    logic [15:0] m_sig, m_ref, m_fcount;
    int          m_cnt;

    // Whole-message CRC: XOR each byte into the top and shift eight times.
    function automatic logic [15:0] msg_crc(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {q[i], 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_synced = 0; m_armed = 0; m_checking = 0; m_valid = 0; m_strobe = 0; m_mis = 0;
        m_sig = 0; m_ref = 0; m_fcount = 0; m_cnt = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                model_reset();
            end else begin
                logic [15:0] c;
                bit done, hit;
                frame_q.push_back({hsync, vsync, rrggbb});
                m_strobe = 0;
                done = 0;
                hit = 0;
                c = '0;
                if (next_frame) begin
                    c = msg_crc(frame_q);
                    frame_q.delete();
                    done = m_synced;
                    m_synced = 1;
                    if (done) begin
                        m_sig = c; m_valid = 1; m_strobe = 1; m_fcount = m_fcount + 16'd1;
                    end
                end
                if (arm) begin
                    m_armed = 1; m_checking = 0;
                end else if (done && m_armed) begin
                    m_ref = c; m_armed = 0; m_checking = 1;
                end else if (done && m_checking && c != m_ref) begin
                    hit = 1;
                end
                if (clear) begin
                    m_mis = 0; m_cnt = 0;
                end else if (hit) begin
                    m_mis = 1;
                    if (m_cnt < (1 << MW) - 1) m_cnt++;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.signature", signature, m_sig);
            chk("m.sig_valid", sig_valid, m_valid);
            chk("m.sig_strobe", sig_strobe, m_strobe);
            chk("m.frame_count", frame_count, m_fcount);
            chk("m.ref_signature", ref_signature, m_ref);
            chk("m.checking", checking, m_checking);
            chk("m.mismatch", mismatch, m_mis);
            chk("m.mismatch_count", mismatch_count, m_cnt);
        end
    end

    // One clock with the given byte/controls; returns just after the edge.
    task automatic cyc(input logic [7:0] b, input bit nf, input bit a, input bit cl);
        @(negedge clk); #1;
        {hsync, vsync, rrggbb} = b;
        next_frame = nf; arm = a; clear = cl;
        @(posedge clk); #1;
    endtask

    task automatic frame9(input int flip, input bit arm_first, input bit arm_last, input bit clr_last);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] b;
            b = 8'h31 + 8'(i);
            if (i == flip) b = b ^ 8'h01;
            cyc(b, i == 8, (i == 0 && arm_first) || (i == 8 && arm_last), i == 8 && clr_last);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".signature"}, signature, 0);
        chk({tag, ".sig_valid"}, sig_valid, 0);
        chk({tag, ".sig_strobe"}, sig_strobe, 0);
        chk({tag, ".frame_count"}, frame_count, 0);
        chk({tag, ".ref_signature"}, ref_signature, 0);
        chk({tag, ".checking"}, checking, 0);
        chk({tag, ".mismatch"}, mismatch, 0);
        chk({tag, ".mismatch_count"}, mismatch_count, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset_n = 0; {hsync, vsync, rrggbb} = '0; next_frame = 0; arm = 0; clear = 0;
        @(posedge clk); #1;
        chk_zero("rst");
        @(negedge clk); #1;
        reset_n = 1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] tq[$];
        tq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("lit.model_crc", msg_crc(tq), 16'h29B1);

        repeat (2) @(posedge clk);
        do_reset();
        cmp_en = 1;

        // first frame after reset is partial
        cyc(8'h00, 1, 0, 0);
        chk("lit.partial_valid", sig_valid, 0);
        chk("lit.partial_fcount", frame_count, 0);

        frame9(-1, 0, 0, 0);
        chk("lit.sig", signature, 16'h29B1);
        chk("lit.strobe", sig_strobe, 1);
        chk("lit.fcount1", frame_count, 1);
        chk("lit.valid", sig_valid, 1);
        cyc(8'h00, 0, 0, 0);
        chk("lit.strobe_off", sig_strobe, 0);
        cyc(8'h00, 1, 0, 0);

        frame9(-1, 1, 0, 0);
        chk("lit.ref", ref_signature, 16'h29B1);
        chk("lit.checking", checking, 1);
        frame9(-1, 0, 0, 0);
        chk("lit.match_mis", mismatch, 0);
        frame9(3, 0, 0, 0);
        chk("lit.mis1", mismatch, 1);
        chk("lit.cnt1", mismatch_count, 1);

        repeat (4) frame9(5, 0, 0, 0);
        chk("lit.cnt_sat", mismatch_count, 3);
        frame9(5, 0, 0, 1);
        chk("lit.clr_mis", mismatch, 0);
        chk("lit.clr_cnt", mismatch_count, 0);
        chk("lit.clr_ref_kept", ref_signature, 16'h29B1);

        frame9(-1, 0, 1, 0);
        chk("lit.armbnd_checking", checking, 0);
        chk("lit.armbnd_ref", ref_signature, 16'h29B1);
        frame9(4, 0, 0, 0);
        q = tq;
        q[4] = q[4] ^ 8'h01;
        chk("lit.recap_ref", ref_signature, msg_crc(q));
        chk("lit.recap_checking", checking, 1);

        do_reset();
        cyc(8'h00, 1, 0, 0);
        repeat (5) frame9(-1, 0, 0, 0);
        chk("lit.fcount5", frame_count, 5);
        cyc(8'h12, 0, 0, 0);
        cyc(8'h34, 0, 0, 0);
        do_reset();
        cyc(8'h56, 1, 0, 0);
        chk("lit.post_rst_partial", frame_count, 0);
        frame9(-1, 0, 0, 0);
        chk("lit.post_rst_fcount", frame_count, 1);

        // randomized run: short frames, sporadic arm/clear/reset
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            reset_n    = ($urandom_range(0, 599) != 0);
            {hsync, vsync, rrggbb} = 8'($urandom);
            next_frame = ($urandom_range(0, 7) == 0);
            arm        = ($urandom_range(0, 39) == 0);
            clear      = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk); #1;
        reset_n = 1; next_frame = 0; arm = 0; clear = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
